// File: rtl/pci_rr_arbiter.sv
// Round-robin PCI bus arbiter with bus parking, grant revocation on idle timeout
// and pre-emption signalling during a transaction.
module pci_rr_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int PARK_MASTER = 0,
  parameter int TIMEOUT     = 16
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_MASTERS-1:0]         req,
  input  logic                           frame_n,
  input  logic                           irdy_n,
  output logic [NUM_MASTERS-1:0]         gnt,
  output logic [$clog2(NUM_MASTERS)-1:0] gnt_idx,
  output logic                           parked
);

  localparam int IW = $clog2(NUM_MASTERS);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] PARK_IDX = IW'(PARK_MASTER);

  typedef enum logic [2:0] {S_IDLE, S_PARK, S_GRANT, S_BUSY, S_GAP} state_t;

  state_t                 state, state_nxt;
  logic [IW-1:0]          owner_nxt, last_winner, last_winner_nxt, win_idx;
  logic [CW-1:0]          cnt, cnt_nxt, cnt_inc;
  logic                   preempt, preempt_nxt;
  logic [NUM_MASTERS-1:0] gnt_nxt;
  logic                   parked_nxt;
  logic                   bus_idle, any_req, other_req;

  function automatic logic [NUM_MASTERS-1:0] onehot(input logic [IW-1:0] i);
    logic [NUM_MASTERS-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // First requester strictly after the last winner, wrapping around.
  function automatic logic [IW-1:0] rr_pick(input logic [NUM_MASTERS-1:0] r,
                                            input logic [IW-1:0] lw);
    logic [IW-1:0] pick;
    logic [IW-1:0] idx;
    logic          found;
    pick  = lw;
    found = 1'b0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      idx = IW'((int'(lw) + i) % NUM_MASTERS);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == {CW{1'b1}}) ? c : c + CW'(1);
  endfunction

  assign bus_idle  = frame_n & irdy_n;
  assign any_req   = |req;
  assign win_idx   = rr_pick(req, last_winner);
  assign other_req = |(req & ~onehot(gnt_idx));
  assign cnt_inc   = sat_inc(cnt);

  always_comb begin
    state_nxt       = state;
    owner_nxt       = gnt_idx;
    last_winner_nxt = last_winner;
    cnt_nxt         = cnt;
    preempt_nxt     = preempt;
    gnt_nxt         = '0;
    parked_nxt      = 1'b0;

    unique case (state)
      S_IDLE, S_GAP: begin
        if (any_req) begin
          state_nxt       = S_GRANT;
          owner_nxt       = win_idx;
          last_winner_nxt = win_idx;
          cnt_nxt         = '0;
        end else begin
          state_nxt = S_PARK;
          owner_nxt = PARK_IDX;
        end
      end
      S_PARK: begin
        if (!frame_n) begin
          state_nxt   = S_BUSY;
          cnt_nxt     = '0;
          preempt_nxt = other_req;
        end else if (any_req) begin
          if (win_idx == PARK_IDX) begin
            state_nxt       = S_GRANT;
            last_winner_nxt = PARK_IDX;
            cnt_nxt         = '0;
          end else begin
            state_nxt = S_GAP;
          end
        end
      end
      S_GRANT: begin
        // A started transaction takes precedence over a same-edge timeout.
        if (!frame_n) begin
          state_nxt   = S_BUSY;
          cnt_nxt     = '0;
          preempt_nxt = other_req;
        end else if (bus_idle && !req[gnt_idx]) begin
          state_nxt = S_GAP;
        end else if (bus_idle) begin
          cnt_nxt = cnt_inc;
          if (cnt_inc >= CW'(TIMEOUT)) state_nxt = S_GAP;
        end
      end
      S_BUSY: begin
        preempt_nxt = preempt | other_req;
        if (bus_idle) begin
          if (any_req) begin
            state_nxt = S_GAP;
          end else begin
            state_nxt = S_PARK;
            owner_nxt = PARK_IDX;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they leave the register stage aligned.
    case (state_nxt)
      S_PARK: begin
        gnt_nxt    = onehot(PARK_IDX);
        parked_nxt = 1'b1;
      end
      S_GRANT: gnt_nxt = onehot(owner_nxt);
      S_BUSY:  gnt_nxt = preempt_nxt ? '0 : onehot(owner_nxt);
      default: gnt_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      gnt_idx     <= '0;
      last_winner <= IW'(NUM_MASTERS - 1);
      cnt         <= '0;
      preempt     <= 1'b0;
      gnt         <= '0;
      parked      <= 1'b0;
    end else begin
      state       <= state_nxt;
      gnt_idx     <= owner_nxt;
      last_winner <= last_winner_nxt;
      cnt         <= cnt_nxt;
      preempt     <= preempt_nxt;
      gnt         <= gnt_nxt;
      parked      <= parked_nxt;
    end
  end

endmodule

// File: tb/tb_pci_rr_arbiter.sv
// Directed bench for pci_rr_arbiter: each step queues the expected registered outputs
// and checks them one edge later.
module tb_pci_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] req;
  logic       frame_n;
  logic       irdy_n;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       parked;

  int n_chk  = 0;
  int n_fail = 0;
  logic [4:0] exp_q[$];

  pci_rr_arbiter #(
    .NUM_MASTERS(4),
    .PARK_MASTER(0),
    .TIMEOUT    (16)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .req    (req),
    .frame_n(frame_n),
    .irdy_n (irdy_n),
    .gnt    (gnt),
    .gnt_idx(gnt_idx),
    .parked (parked)
  );

  always #5 clk = ~clk;

  task automatic check_reset(input string tag);
    n_chk++;
    assert (gnt === 4'b0000) else begin
      n_fail++;
      $error("FAIL %s gnt observed %b expected 0000", tag, gnt);
    end
    n_chk++;
    assert (parked === 1'b0) else begin
      n_fail++;
      $error("FAIL %s parked observed %b expected 0", tag, parked);
    end
    n_chk++;
    assert (gnt_idx === 2'd0) else begin
      n_fail++;
      $error("FAIL %s gnt_idx observed %0d expected 0", tag, gnt_idx);
    end
  endtask

  // Called at a falling edge; asserts reset mid-cycle and releases it a cycle later.
  task automatic do_reset(input logic [3:0] r, input string tag);
    reset_n = 1'b0;
    req     = r;
    frame_n = 1'b1;
    irdy_n  = 1'b1;
    #1;
    check_reset(tag);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Called at a falling edge; drives inputs, checks outputs after the next rising edge.
  task automatic step(input logic [3:0] r, input logic f, input logic i,
                      input logic [3:0] eg, input logic ep, input string tag);
    logic [4:0] e;
    logic [1:0] ei;
    req     = r;
    frame_n = f;
    irdy_n  = i;
    exp_q.push_back({eg, ep});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    n_chk++;
    assert (gnt === e[4:1]) else begin
      n_fail++;
      $error("FAIL %s gnt observed %b expected %b", tag, gnt, e[4:1]);
    end
    n_chk++;
    assert (parked === e[0]) else begin
      n_fail++;
      $error("FAIL %s parked observed %b expected %b", tag, parked, e[0]);
    end
    if (e[4:1] != 4'b0000) begin
      ei = 2'd0;
      for (int k = 0; k < 4; k++) if (e[1+k]) ei = 2'(k);
      n_chk++;
      assert (gnt_idx === ei) else begin
        n_fail++;
        $error("FAIL %s gnt_idx observed %0d expected %0d", tag, gnt_idx, ei);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    req     = 4'b1111;
    frame_n = 1'b1;
    irdy_n  = 1'b1;
    @(negedge clk);
    check_reset("rst_hold");
    reset_n = 1'b1;
    step(4'b1111, 1, 1, 4'b0001, 0, "rst_first_grant");

    // Round robin: each owner runs address, data, last-data, then the bus goes idle.
    for (int k = 1; k <= 4; k++) begin
      step(4'b1111, 0, 1, 4'b0000, 0, "rr_addr_preempt");
      step(4'b1111, 0, 0, 4'b0000, 0, "rr_data");
      step(4'b1111, 1, 0, 4'b0000, 0, "rr_last");
      step(4'b1111, 1, 1, 4'b0000, 0, "rr_gap");
      step(4'b1111, 1, 1, 4'b0001 << (k % 4), 0, "rr_grant");
    end

    // Parking, then a non-park request goes through a gap.
    do_reset(4'b0000, "rst_park");
    step(4'b0000, 1, 1, 4'b0001, 1, "park_enter");
    step(4'b0000, 1, 1, 4'b0001, 1, "park_hold");
    step(4'b0100, 1, 1, 4'b0000, 0, "park_gap");
    step(4'b0100, 1, 1, 4'b0100, 0, "park_grant2");
    step(4'b0000, 1, 1, 4'b0000, 0, "grant_drop_gap");
    step(4'b0000, 1, 1, 4'b0001, 1, "repark");
    step(4'b0001, 1, 1, 4'b0001, 0, "park_to_grant0");

    // Timeout revocation of master 1, then master 0 wins.
    do_reset(4'b0010, "rst_to");
    step(4'b0010, 1, 1, 4'b0010, 0, "to_grant");
    for (int k = 1; k <= 15; k++) step(4'b0011, 1, 1, 4'b0010, 0, "to_hold");
    step(4'b0011, 1, 1, 4'b0000, 0, "to_revoke");
    step(4'b0011, 1, 1, 4'b0001, 0, "to_next");

    // FRAME# on the timeout edge wins.
    do_reset(4'b0010, "rst_fw");
    step(4'b0010, 1, 1, 4'b0010, 0, "fw_grant");
    for (int k = 1; k <= 15; k++) step(4'b0010, 1, 1, 4'b0010, 0, "fw_hold");
    step(4'b0010, 0, 1, 4'b0010, 0, "fw_frame_wins");
    step(4'b0010, 1, 1, 4'b0000, 0, "fw_gap");
    step(4'b0010, 1, 1, 4'b0010, 0, "fw_regrant");

    // Pre-emption during master 0's transaction.
    do_reset(4'b0001, "rst_pre");
    step(4'b0001, 1, 1, 4'b0001, 0, "pre_grant");
    step(4'b0001, 0, 1, 4'b0001, 0, "pre_busy");
    step(4'b0001, 0, 0, 4'b0001, 0, "pre_busy_data");
    step(4'b1001, 0, 0, 4'b0000, 0, "pre_drop");
    step(4'b1001, 1, 0, 4'b0000, 0, "pre_last");
    step(4'b1001, 1, 1, 4'b0000, 0, "pre_gap");
    step(4'b1001, 1, 1, 4'b1000, 0, "pre_grant3");

    // Reset while busy.
    do_reset(4'b0001, "rst_mid");
    step(4'b0001, 1, 1, 4'b0001, 0, "mid_grant");
    step(4'b0001, 0, 1, 4'b0001, 0, "mid_busy");
    do_reset(4'b0001, "rst_in_busy");
    step(4'b0001, 1, 1, 4'b0001, 0, "mid_regrant");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
